// File: rtl/xnor_gate.sv
// Registered N-bit bitwise XNOR with an all-equal flag and a match count.
// The status outputs are qualified by in_valid.
module xnor_gate #(
    parameter  int unsigned N  = 1,
    localparam int unsigned CW = ($clog2(N + 1) < 1) ? 1 : $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  a,
    input  logic [N-1:0]  b,
    input  logic          in_valid,
    output logic [N-1:0]  c,
    output logic          out_valid,
    output logic          all_eq,
    output logic [CW-1:0] match_cnt
);

    logic [N-1:0]  xnor_w;
    logic [CW-1:0] pop_w;

    logic [N-1:0]  c_d,         c_q;
    logic          out_valid_d, out_valid_q;
    logic          all_eq_d,    all_eq_q;
    logic [CW-1:0] match_cnt_d, match_cnt_q;

    // Bitwise XNOR and its popcount; the status pair holds unless in_valid is high
    always_comb begin
        xnor_w = ~(a ^ b);
        pop_w  = '0;
        for (int unsigned i = 0; i < N; i++) begin
            pop_w = pop_w + CW'(xnor_w[i]);
        end

        c_d         = xnor_w;
        out_valid_d = in_valid;
        all_eq_d    = all_eq_q;
        match_cnt_d = match_cnt_q;
        if (in_valid) begin
            all_eq_d    = &xnor_w;
            match_cnt_d = pop_w;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            c_q         <= '0;
            out_valid_q <= 1'b0;
            all_eq_q    <= 1'b0;
            match_cnt_q <= '0;
        end else begin
            c_q         <= c_d;
            out_valid_q <= out_valid_d;
            all_eq_q    <= all_eq_d;
            match_cnt_q <= match_cnt_d;
        end
    end

    assign c         = c_q;
    assign out_valid = out_valid_q;
    assign all_eq    = all_eq_q;
    assign match_cnt = match_cnt_q;

endmodule

// File: tb/tb_xnor_gate.sv
// Bench for xnor_gate: three widths (1, 8, 13) driven side by side and checked
// every cycle against a one-cycle-delayed arithmetic reference model.
module tb_xnor_gate;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        a1, b1, v1;
    logic        c1, ov1, eq1;
    logic        cnt1;
    logic [7:0]  a8, b8, c8;
    logic        v8, ov8, eq8;
    logic [3:0]  cnt8;
    logic [12:0] a13, b13, c13;
    logic        v13, ov13, eq13;
    logic [3:0]  cnt13;

    xnor_gate #(.N(1)) u_n1 (
        .clk(clk), .rst(rst), .a(a1), .b(b1), .in_valid(v1),
        .c(c1), .out_valid(ov1), .all_eq(eq1), .match_cnt(cnt1)
    );
    xnor_gate #(.N(8)) u_n8 (
        .clk(clk), .rst(rst), .a(a8), .b(b8), .in_valid(v8),
        .c(c8), .out_valid(ov8), .all_eq(eq8), .match_cnt(cnt8)
    );
    xnor_gate #(.N(13)) u_n13 (
        .clk(clk), .rst(rst), .a(a13), .b(b13), .in_valid(v13),
        .c(c13), .out_valid(ov13), .all_eq(eq13), .match_cnt(cnt13)
    );

    int vectors = 0;
    int errors  = 0;

    // Reference state per instance: index 0 -> N=1, 1 -> N=8, 2 -> N=13
    logic [63:0] m_c   [3];
    logic        m_v   [3];
    logic        m_eq  [3];
    logic [63:0] m_cnt [3];

    task automatic model_upd(input int k, input logic [63:0] a, input logic [63:0] b,
                             input logic v, input int w);
        logic [63:0] mask;
        logic [63:0] am, bm;
        mask = (64'd1 << w) - 64'd1;
        am   = a & mask;
        bm   = b & mask;
        if (rst) begin
            m_c[k] = '0; m_v[k] = 1'b0; m_eq[k] = 1'b0; m_cnt[k] = '0;
        end else begin
            m_c[k] = ~(am ^ bm) & mask;
            m_v[k] = v;
            if (v) begin
                m_eq[k]  = (am == bm);
                m_cnt[k] = 64'(w) - 64'($countones(am ^ bm));
            end
        end
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("n1.c",     64'(c1),    m_c[0]);
        check("n1.valid", 64'(ov1),   64'(m_v[0]));
        check("n1.eq",    64'(eq1),   64'(m_eq[0]));
        check("n1.cnt",   64'(cnt1),  m_cnt[0]);
        check("n8.c",     64'(c8),    m_c[1]);
        check("n8.valid", 64'(ov8),   64'(m_v[1]));
        check("n8.eq",    64'(eq8),   64'(m_eq[1]));
        check("n8.cnt",   64'(cnt8),  m_cnt[1]);
        check("n13.c",    64'(c13),   m_c[2]);
        check("n13.valid",64'(ov13),  64'(m_v[2]));
        check("n13.eq",   64'(eq13),  64'(m_eq[2]));
        check("n13.cnt",  64'(cnt13), m_cnt[2]);
        if (ov13 === 1'b1) begin
            check("n13.inv_eq",  64'(eq13),  64'(cnt13 == 4'd13));
            check("n13.inv_pop", 64'(cnt13), 64'($countones(c13)));
        end
    endtask

    // Advance one edge, update the model with the inputs seen at that edge, then compare
    task automatic tick();
        @(posedge clk);
        model_upd(0, 64'(a1),  64'(b1),  v1,  1);
        model_upd(1, 64'(a8),  64'(b8),  v8,  8);
        model_upd(2, 64'(a13), 64'(b13), v13, 13);
        #1;
        check_all();
    endtask

    logic [1:0] tt_in  [4];
    logic       tt_exp [4];

    initial begin
        tt_in  = '{2'b00, 2'b01, 2'b11, 2'b10};
        tt_exp = '{1'b1, 1'b0, 1'b1, 1'b0};
        for (int k = 0; k < 3; k++) begin
            m_c[k] = '0; m_v[k] = 1'b0; m_eq[k] = 1'b0; m_cnt[k] = '0;
        end

        // Reset held for two edges with live inputs
        rst = 1'b1;
        a1 = 1'b1; b1 = 1'b0; v1 = 1'b1;
        a8 = 8'hFF; b8 = 8'h00; v8 = 1'b1;
        a13 = 13'h1ABC; b13 = 13'h0123; v13 = 1'b1;
        repeat (2) begin
            tick();
            check("rst.c8",   64'(c8),   64'h0);
            check("rst.cnt8", 64'(cnt8), 64'h0);
        end

        // N=1 truth table
        rst = 1'b0;
        v8 = 1'b0; v13 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a1 = tt_in[i][1]; b1 = tt_in[i][0]; v1 = 1'b1;
            tick();
            check("tt.c1",   64'(c1),   64'(tt_exp[i]));
            check("tt.eq1",  64'(eq1),  64'(tt_exp[i]));
            check("tt.cnt1", 64'(cnt1), 64'(tt_exp[i]));
        end

        // N=8 directed patterns
        v8 = 1'b1; a8 = 8'hA5; b8 = 8'hA5;
        tick();
        check("n8.eq_c",   64'(c8),   64'hFF);
        check("n8.eq_cnt", 64'(cnt8), 64'd8);
        check("n8.eq_flag",64'(eq8),  64'd1);
        a8 = 8'hA5; b8 = 8'h5A;
        tick();
        check("n8.inv_c",   64'(c8),   64'h00);
        check("n8.inv_cnt", 64'(cnt8), 64'd0);
        a8 = 8'hF0; b8 = 8'hFF;
        tick();
        check("n8.half_c",   64'(c8),   64'hF0);
        check("n8.half_cnt", 64'(cnt8), 64'd4);

        // Valid gating: status holds while c keeps tracking
        a8 = 8'h00; b8 = 8'h00; v8 = 1'b0;
        tick();
        check("gate.valid", 64'(ov8),  64'd0);
        check("gate.c",     64'(c8),   64'hFF);
        check("gate.eq",    64'(eq8),  64'd0);
        check("gate.cnt",   64'(cnt8), 64'd4);

        // Reset mid-stream
        v1 = 1'b1; v8 = 1'b1; v13 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            a8 = 8'($urandom); b8 = 8'($urandom);
            a13 = 13'($urandom); b13 = 13'($urandom);
            rst = (i == 3);
            tick();
            if (i == 3) begin
                check("mid.valid", 64'(ov13), 64'd0);
                check("mid.c13",   64'(c13),  64'd0);
            end
        end
        rst = 1'b0;

        // Random regression, mainly on N=13 but every instance keeps being checked
        for (int i = 0; i < 1000; i++) begin
            a1 = 1'($urandom); b1 = 1'($urandom); v1 = 1'($urandom);
            a8 = 8'($urandom); b8 = ($urandom_range(0, 3) == 0) ? a8 : 8'($urandom);
            v8 = 1'($urandom);
            a13 = 13'($urandom);
            b13 = ($urandom_range(0, 4) == 0) ? a13 : (a13 ^ 13'($urandom & $urandom));
            v13 = ($urandom_range(0, 3) != 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
